// File: rtl/ccl_pkg.sv
// Shared definitions for the connected-component labelling requester:
// union-find opcodes and the requester FSM state encoding.
package ccl_pkg;

    localparam logic [1:0] UF_IDLE  = 2'b00;
    localparam logic [1:0] UF_UNION = 2'b01;
    localparam logic [1:0] UF_FIND  = 2'b10;

    typedef enum logic [2:0] {
        ST_SCAN      = 3'd0,
        ST_UN_ISSUE  = 3'd1,
        ST_UN_WAIT   = 3'd2,
        ST_RES_ISSUE = 3'd3,
        ST_RES_WAIT  = 3'd4,
        ST_RES_OUT   = 3'd5,
        ST_FIN       = 3'd6
    } ccl_state_e;

endpackage

// File: rtl/ccl_line_buffer.sv
// One row of provisional labels: write on pixel accept, asynchronous read of
// the same column gives the "up" neighbour before it is overwritten.
module ccl_line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; row-0 gating in the requester makes stale
    // contents unobservable, and a reset would prevent RAM mapping.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ccl_uf_requester.sv
// First-pass 4-connectivity labeller: assigns provisional labels, issues UNIONs
// on left/up conflicts, then FINDs every label and streams (label, root) pairs.
module ccl_uf_requester
    import ccl_pkg::*;
#(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 48,
    parameter int N          = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic                  pix_bit,
    output logic                  lbl_valid,
    output logic [ADDR_WIDTH-1:0] lbl_data,
    output logic [1:0]            uf_op,
    output logic [ADDR_WIDTH-1:0] uf_node1,
    output logic [ADDR_WIDTH-1:0] uf_node2,
    input  logic [ADDR_WIDTH-1:0] uf_result,
    input  logic                  uf_done,
    output logic                  eq_valid,
    input  logic                  eq_ready,
    output logic [ADDR_WIDTH-1:0] eq_label,
    output logic [ADDR_WIDTH-1:0] eq_root,
    output logic                  eq_last,
    output logic                  frame_done,
    output logic                  lbl_ovf
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [ADDR_WIDTH-1:0] LBL_MAX = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] LBL_ONE = ADDR_WIDTH'(1);

    ccl_state_e            state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [ADDR_WIDTH-1:0] next_label_q, next_label_d;
    logic                  sat_q, sat_d;
    logic [ADDR_WIDTH-1:0] left_q, left_d;
    logic                  ovf_q, ovf_d;
    logic                  lbl_valid_q, lbl_valid_d;
    logic [ADDR_WIDTH-1:0] lbl_data_q, lbl_data_d;
    logic                  pix_ready_q, pix_ready_d;
    logic [ADDR_WIDTH-1:0] node1_q, node1_d;
    logic [ADDR_WIDTH-1:0] node2_q, node2_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [ADDR_WIDTH-1:0] root_q, root_d;

    logic                  accept;
    logic                  is_last;
    logic [ADDR_WIDTH-1:0] lb_rdata;
    logic [ADDR_WIDTH-1:0] up_lbl;
    logic [ADDR_WIDTH-1:0] left_lbl;
    logic [ADDR_WIDTH-1:0] last_label;
    logic [ADDR_WIDTH-1:0] pix_lbl;
    logic                  alloc;
    logic                  reuse;
    logic                  need_union;
    logic                  start_res;

    ccl_line_buffer #(
        .DEPTH(IMG_W),
        .WIDTH(ADDR_WIDTH),
        .AW   (CW)
    ) u_line_buffer (
        .clk    (clk),
        .we_i   (accept),
        .waddr_i(col_q),
        .wdata_i(pix_lbl),
        .raddr_i(col_q),
        .rdata_o(lb_rdata)
    );

    assign accept     = (state_q == ST_SCAN) && pix_ready_q && pix_valid;
    assign is_last    = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign up_lbl     = (row_q == '0) ? '0 : lb_rdata;
    assign left_lbl   = (col_q == '0) ? '0 : left_q;
    // Once saturated, every allocated label up to N-1 exists and must be resolved.
    assign last_label = sat_q ? LBL_MAX : (next_label_q - LBL_ONE);

    // NOTE: every variable gets a default before the branches so no latch is inferred.
    always_comb begin
        pix_lbl    = '0;
        alloc      = 1'b0;
        reuse      = 1'b0;
        need_union = 1'b0;
        if (pix_bit) begin
            if (left_lbl == '0 && up_lbl == '0) begin
                if (sat_q) begin
                    pix_lbl = LBL_MAX;
                    reuse   = 1'b1;
                end else begin
                    pix_lbl = next_label_q;
                    alloc   = 1'b1;
                end
            end else if (left_lbl == '0) begin
                pix_lbl = up_lbl;
            end else begin
                pix_lbl    = left_lbl;
                need_union = (up_lbl != '0) && (up_lbl != left_lbl);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        next_label_d = next_label_q;
        sat_d        = sat_q;
        left_d       = left_q;
        ovf_d        = ovf_q;
        lbl_valid_d  = 1'b0;
        lbl_data_d   = lbl_data_q;
        node1_d      = node1_q;
        node2_d      = node2_q;
        last_d       = last_q;
        k_d          = k_q;
        root_d       = root_q;
        start_res    = 1'b0;

        unique case (state_q)
            ST_SCAN: begin
                if (accept) begin
                    lbl_valid_d = 1'b1;
                    lbl_data_d  = pix_lbl;
                    left_d      = pix_lbl;
                    if (alloc) begin
                        if (next_label_q == LBL_MAX) sat_d = 1'b1;
                        else                         next_label_d = next_label_q + LBL_ONE;
                    end
                    if (reuse) ovf_d = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = is_last ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (need_union) begin
                        state_d = ST_UN_ISSUE;
                        node1_d = left_lbl;
                        node2_d = up_lbl;
                        last_d  = is_last;
                    end else if (is_last) begin
                        start_res = 1'b1;
                    end
                end
            end
            ST_UN_ISSUE: state_d = ST_UN_WAIT;
            ST_UN_WAIT: begin
                if (uf_done) begin
                    if (last_q) start_res = 1'b1;
                    else        state_d   = ST_SCAN;
                end
            end
            ST_RES_ISSUE: state_d = ST_RES_WAIT;
            ST_RES_WAIT: begin
                if (uf_done) begin
                    root_d  = uf_result;
                    state_d = ST_RES_OUT;
                end
            end
            ST_RES_OUT: begin
                if (eq_ready) begin
                    if (k_q == last_label) begin
                        state_d = ST_FIN;
                    end else begin
                        k_d     = k_q + LBL_ONE;
                        node1_d = k_q + LBL_ONE;
                        state_d = ST_RES_ISSUE;
                    end
                end
            end
            ST_FIN: begin
                state_d      = ST_SCAN;
                row_d        = '0;
                col_d        = '0;
                next_label_d = LBL_ONE;
                sat_d        = 1'b0;
                ovf_d        = 1'b0;
            end
            default: state_d = ST_SCAN;
        endcase

        // A frame with no foreground skips the resolve pass entirely.
        if (start_res) begin
            if (!sat_d && next_label_d == LBL_ONE) begin
                state_d = ST_FIN;
            end else begin
                state_d = ST_RES_ISSUE;
                k_d     = LBL_ONE;
                node1_d = LBL_ONE;
                node2_d = '0;
            end
        end

        pix_ready_d = (state_d == ST_SCAN);
    end

    // NOTE: non-blocking assignments so all state updates together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SCAN;
            row_q        <= '0;
            col_q        <= '0;
            next_label_q <= LBL_ONE;
            sat_q        <= 1'b0;
            left_q       <= '0;
            ovf_q        <= 1'b0;
            lbl_valid_q  <= 1'b0;
            lbl_data_q   <= '0;
            pix_ready_q  <= 1'b0;
            node1_q      <= '0;
            node2_q      <= '0;
            last_q       <= 1'b0;
            k_q          <= '0;
            root_q       <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            next_label_q <= next_label_d;
            sat_q        <= sat_d;
            left_q       <= left_d;
            ovf_q        <= ovf_d;
            lbl_valid_q  <= lbl_valid_d;
            lbl_data_q   <= lbl_data_d;
            pix_ready_q  <= pix_ready_d;
            node1_q      <= node1_d;
            node2_q      <= node2_d;
            last_q       <= last_d;
            k_q          <= k_d;
            root_q       <= root_d;
        end
    end

    assign pix_ready  = pix_ready_q;
    assign lbl_valid  = lbl_valid_q;
    assign lbl_data   = lbl_data_q;
    assign uf_op      = (state_q == ST_UN_ISSUE)  ? UF_UNION :
                        (state_q == ST_RES_ISSUE) ? UF_FIND  : UF_IDLE;
    assign uf_node1   = node1_q;
    assign uf_node2   = node2_q;
    assign eq_valid   = (state_q == ST_RES_OUT);
    assign eq_label   = k_q;
    assign eq_root    = root_q;
    assign eq_last    = (state_q == ST_RES_OUT) && (k_q == last_label);
    assign frame_done = (state_q == ST_FIN);
    assign lbl_ovf    = ovf_q;

endmodule

// File: tb/tb_ccl_uf_requester.sv
// Directed bench for ccl_uf_requester on a 4x3 image with N=4, driven against
// a small behavioural union-find engine.
module tb_ccl_uf_requester;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pix_valid, pix_ready, pix_bit;
    logic       lbl_valid;
    logic [1:0] lbl_data;
    logic [1:0] uf_op, uf_node1, uf_node2, uf_result;
    logic       uf_done;
    logic       eq_valid, eq_ready, eq_last;
    logic [1:0] eq_label, eq_root;
    logic       frame_done, lbl_ovf;

    always #5 clk = ~clk;

    ccl_uf_requester #(.IMG_W(4), .IMG_H(3), .N(4), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_bit(pix_bit),
        .lbl_valid(lbl_valid), .lbl_data(lbl_data),
        .uf_op(uf_op), .uf_node1(uf_node1), .uf_node2(uf_node2),
        .uf_result(uf_result), .uf_done(uf_done),
        .eq_valid(eq_valid), .eq_ready(eq_ready), .eq_label(eq_label),
        .eq_root(eq_root), .eq_last(eq_last),
        .frame_done(frame_done), .lbl_ovf(lbl_ovf)
    );

    typedef struct {
        logic       pbit;
        logic [1:0] lbl;
        logic       un;
        logic [1:0] n1;
        logic [1:0] n2;
    } pix_vec_t;

    typedef struct {
        logic [1:0] lbl;
        logic [1:0] root;
        logic       last;
    } eq_vec_t;

    pix_vec_t pv[$];
    eq_vec_t  ev[$];

    int n_vec = 0;
    int n_err = 0;
    int union_cnt = 0, find_cnt = 0, fd_cnt = 0, beat_cnt = 0;
    int proto_err = 0, rdy_err = 0;

    // Behavioural union-find engine: fixed latency, links larger root under smaller.
    logic [1:0] par [4];
    logic       busy;
    int         cnt;
    logic [1:0] rx, ry;

    function automatic logic [1:0] root_of(input logic [1:0] x);
        logic [1:0] r;
        r = x;
        for (int i = 0; i < 4; i++) r = par[r];
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) par[i] <= 2'(i);
            busy      <= 1'b0;
            cnt       <= 0;
            uf_done   <= 1'b0;
            uf_result <= '0;
        end else begin
            uf_done <= 1'b0;
            if (uf_op != 2'b00 && (busy || uf_done)) proto_err <= proto_err + 1;
            if (busy) begin
                if (cnt == 0) begin
                    busy    <= 1'b0;
                    uf_done <= 1'b1;
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (uf_op != 2'b00) begin
                busy <= 1'b1;
                cnt  <= 2;
                rx = root_of(uf_node1);
                ry = root_of(uf_node2);
                if (uf_op == 2'b01) begin
                    if (rx < ry)      par[ry] <= rx;
                    else if (ry < rx) par[rx] <= ry;
                    uf_result <= (rx < ry) ? rx : ry;
                end else begin
                    uf_result <= rx;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (uf_op == 2'b01) union_cnt++;
        if (uf_op == 2'b10) find_cnt++;
        if (frame_done) fd_cnt++;
        if (eq_valid && eq_ready) beat_cnt++;
        if (pix_ready && (busy || uf_done)) rdy_err++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void px(input logic b, input logic [1:0] l);
        pix_vec_t v;
        v.pbit = b; v.lbl = l; v.un = 1'b0; v.n1 = '0; v.n2 = '0;
        pv.push_back(v);
    endfunction

    function automatic void pu(input logic [1:0] l, input logic [1:0] a, input logic [1:0] b);
        pix_vec_t v;
        v.pbit = 1'b1; v.lbl = l; v.un = 1'b1; v.n1 = a; v.n2 = b;
        pv.push_back(v);
    endfunction

    function automatic void ex(input logic [1:0] l, input logic [1:0] r, input logic last);
        eq_vec_t e;
        e.lbl = l; e.root = r; e.last = last;
        ev.push_back(e);
    endfunction

    task automatic send_pixel(input pix_vec_t v, input string tag);
        int guard;
        guard = 0;
        while (pix_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_ready"}, pix_ready, 1'b1);
        pix_valid = 1'b1;
        pix_bit   = v.pbit;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_bit   = 1'b0;
        check({tag, "_lbl_valid"}, lbl_valid, 1'b1);
        check({tag, "_lbl_data"}, lbl_data, v.lbl);
        if (v.un) begin
            check({tag, "_union_op"}, uf_op, 2'b01);
            check({tag, "_union_n1"}, uf_node1, v.n1);
            check({tag, "_union_n2"}, uf_node2, v.n2);
            check({tag, "_union_stall"}, pix_ready, 1'b0);
            @(posedge clk); #1;
            check({tag, "_union_op_drop"}, uf_op, 2'b00);
        end
    endtask

    task automatic run_frame(input string tag, input int pbase, input int eqbase, input int neq,
                             input int stall, input logic exp_ovf, input int exp_un, input int exp_fi);
        int un0, fi0, fd0, bt0, guard;
        logic stable;
        un0 = union_cnt; fi0 = find_cnt; fd0 = fd_cnt; bt0 = beat_cnt;
        for (int i = 0; i < 12; i++) send_pixel(pv[pbase + i], $sformatf("%s_px%0d", tag, i));
        check({tag, "_ovf_end"}, lbl_ovf, exp_ovf);
        for (int j = 0; j < neq; j++) begin
            guard = 0;
            while (eq_valid !== 1'b1 && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            check($sformatf("%s_eq%0d_valid", tag, j), eq_valid, 1'b1);
            check($sformatf("%s_eq%0d_label", tag, j), eq_label, ev[eqbase + j].lbl);
            check($sformatf("%s_eq%0d_root", tag, j), eq_root, ev[eqbase + j].root);
            check($sformatf("%s_eq%0d_last", tag, j), eq_last, ev[eqbase + j].last);
            if (stall > 0) begin
                stable = 1'b1;
                repeat (stall) begin
                    @(posedge clk); #1;
                    if (eq_valid !== 1'b1 || eq_label !== ev[eqbase + j].lbl ||
                        eq_root !== ev[eqbase + j].root || eq_last !== ev[eqbase + j].last)
                        stable = 1'b0;
                end
                check($sformatf("%s_eq%0d_stable", tag, j), stable, 1'b1);
            end
            eq_ready = 1'b1;
            @(posedge clk); #1;
            eq_ready = 1'b0;
        end
        guard = 0;
        while (fd_cnt == fd0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_frame_done_pulses"}, fd_cnt - fd0, 1);
        check({tag, "_eq_beats"}, beat_cnt - bt0, neq);
        check({tag, "_unions"}, union_cnt - un0, exp_un);
        check({tag, "_finds"}, find_cnt - fi0, exp_fi);
        check({tag, "_ovf_cleared"}, lbl_ovf, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; pix_valid = 1'b0; pix_bit = 1'b0; eq_ready = 1'b0;

        // Pixel tables: A single pixel (base 0), D all-zero (12), E overflow (24), B merge (36).
        px(1, 1); for (int i = 0; i < 11; i++) px(0, 0);
        for (int i = 0; i < 12; i++) px(0, 0);
        px(1, 1); px(0, 0); px(1, 2); px(0, 0);
        px(0, 0); px(1, 3); px(0, 0); px(1, 3);
        px(1, 3); px(0, 0); px(1, 3); px(0, 0);
        px(1, 1); px(0, 0); px(0, 0); px(1, 2);
        px(1, 1); px(0, 0); px(0, 0); px(1, 2);
        px(1, 1); px(1, 1); px(1, 1); pu(1, 1, 2);
        // Equivalence tables: A (0), E (1..3), B (4..5).
        ex(1, 1, 1);
        ex(1, 1, 0); ex(2, 2, 0); ex(3, 3, 1);
        ex(1, 1, 0); ex(2, 1, 1);

        repeat (3) @(posedge clk); #1;
        check("rst_pix_ready", pix_ready, 1'b0);
        check("rst_uf_op", uf_op, 2'b00);
        check("rst_all_outputs", {pix_ready, lbl_valid, lbl_data, uf_op, uf_node1, uf_node2,
                                  eq_valid, eq_label, eq_root, eq_last, frame_done, lbl_ovf}, '0);
        @(negedge clk) reset_n = 1'b1;

        run_frame("A", 0, 0, 1, 0, 1'b0, 0, 1);
        run_frame("D", 12, 0, 0, 0, 1'b0, 0, 0);
        run_frame("E", 24, 1, 3, 0, 1'b1, 0, 3);
        run_frame("B", 36, 4, 2, 0, 1'b0, 1, 2);
        run_frame("C", 36, 4, 2, 5, 1'b0, 1, 2);

        // Reset while the final UNION of the frame is outstanding.
        for (int i = 0; i < 12; i++) send_pixel(pv[36 + i], $sformatf("F_px%0d", i));
        reset_n = 1'b0;
        #1;
        check("F_rst_pix_ready", pix_ready, 1'b0);
        check("F_rst_all_outputs", {pix_ready, lbl_valid, lbl_data, uf_op, uf_node1, uf_node2,
                                    eq_valid, eq_label, eq_root, eq_last, frame_done, lbl_ovf}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        run_frame("G", 0, 0, 1, 0, 1'b0, 0, 1);

        check("engine_protocol_errors", proto_err, 0);
        check("pix_ready_while_busy", rdy_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
